display_ctrl: RTL

Controller for the 4-digit BCD display register and the 7-segment output. It arbitrates write access between two requesters (round-robin) and drives the register's write enable and number input through a req/ack handshake. It also time-multiplexes the register's BCD output onto a common 4-anode 7-segment display, with frame-synchronous update and leading-zero blanking.

---
 rtl/display_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/display_ctrl.sv
// Display controller: round-robin write arbiter for the BCD display register plus 4-digit 7-segment scan.
// Latency: write strobe 1 cycle after a sampled request, ack 1 cycle later; scan outputs are registered.
// Backpressure: requests are held off while busy and served once the FSM returns to IDLE (req must stay high).
// Ports: clock/reset_n; req0/num0/ack0 and req1/num1/ack1 requester handshakes; disp_we/disp_num to the
//        display register; bcd from the register; an/seg active-low display drive; busy = FSM not IDLE.
// Optional feature: define DISP_SAT_EN to saturate granted values above 9999 to 9999 on disp_num.
module display_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int NUM_W    = 14
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [NUM_W-1:0] num0,
    output logic             ack0,
    input  logic             req1,
    input  logic [NUM_W-1:0] num1,
    output logic             ack1,
    output logic             disp_we,
    output logic [NUM_W-1:0] disp_num,
    input  logic [15:0]      bcd,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             busy
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t           state;
    logic             grant;   // requester currently being served
    logic             ptr;     // requester preferred on a tie (the one not granted last)
    logic             sel;
    logic [NUM_W-1:0] sel_num;

    function automatic logic [NUM_W-1:0] limit(input logic [NUM_W-1:0] v);
`ifdef DISP_SAT_EN
        logic [NUM_W-1:0] sat_max;
        sat_max = NUM_W'(9999);
        limit   = (v > sat_max) ? sat_max : v;
`else
        limit = v;
`endif
    endfunction

    // A lone requester always wins; on a tie the pointer decides.
    always_comb begin
        sel     = (req0 & req1) ? ptr : req1;
        sel_num = sel ? num1 : num0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= 1'b0;
            ptr      <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            disp_we  <= 1'b0;
            disp_num <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        state    <= WRITE;
                        grant    <= sel;
                        disp_we  <= 1'b1;
                        disp_num <= limit(sel_num);  // value captured here; later num changes ignored
                        busy     <= 1'b1;
                    end
                end
                WRITE: begin
                    disp_we <= 1'b0;
                    ack0    <= ~grant;
                    ack1    <= grant;
                    state   <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    ptr   <= ~grant;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- display scan ----------------
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [15:0]      frame_bcd;
    logic             div_tc;
    logic [1:0]       idx_n;
    logic [15:0]      frame_n;
    logic [3:0]       nib_n;
    logic             blank_n;
    logic [6:0]       seg_n;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;  // non-BCD nibble shown as "-"
        endcase
    endfunction

    // an/seg are computed from the next index and next frame so both change on the same edge.
    always_comb begin
        div_tc  = (div == DIV_W'(SCAN_DIV - 1));
        idx_n   = div_tc ? idx + 2'd1 : idx;
        frame_n = (div_tc && idx == 2'd3) ? bcd : frame_bcd;
        nib_n   = frame_n[4*idx_n +: 4];
        case (idx_n)
            2'd1:    blank_n = (frame_n[15:4]  == 12'd0);
            2'd2:    blank_n = (frame_n[15:8]  == 8'd0);
            2'd3:    blank_n = (frame_n[15:12] == 4'd0);
            default: blank_n = 1'b0;
        endcase
        seg_n = blank_n ? 7'b1111111 : decode(nib_n);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div       <= '0;
            idx       <= 2'd0;
            frame_bcd <= 16'd0;
            an        <= 4'b1110;
            seg       <= 7'b1000000;
        end else begin
            div       <= div_tc ? '0 : div + DIV_W'(1);
            idx       <= idx_n;
            frame_bcd <= frame_n;
            an        <= ~(4'b0001 << idx_n);
            seg       <= seg_n;
        end
    end

endmodule
